// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and FSM state type shared by the multicycle ALU.
package alu_pkg;
    localparam logic [2:0] OP_MUL = 3'b000;
    localparam logic [2:0] OP_XOR = 3'b001;
    localparam logic [2:0] OP_BEQ = 3'b010;
    localparam logic [2:0] OP_BLT = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_AND = 3'b110;
    localparam logic [2:0] OP_OR  = 3'b111;
    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_MUL, ST_DONE} state_t;
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: shift-add multiplier, one multiplier bit per step (LSB first), WIDTH steps after load.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_res
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    logic [WIDTH-1:0] r_acc, r_mcand, r_mplier;
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (i_load) begin
            r_acc    <= '0;
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_cnt    <= CNT_W'(WIDTH);
        end else if (i_step && r_cnt != '0) begin
            r_acc    <= r_acc + (r_mplier[0] ? r_mcand : '0);
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CNT_W'(1);
        end
    end
    assign o_done = (r_cnt == '0);
    assign o_res  = r_acc;
endmodule

// File: rtl/alu_mc.sv
// alu_mc: registered multicycle ALU with start/done handshake.
// Define ALU_MUL_EN to build the iterative multiplier for opcode 000; otherwise 000 is flagged illegal.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] ip_0,
    input  logic [WIDTH-1:0] ip_1,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] op_0,
    output logic             change_pc,
    output logic             illegal
);
    state_t           r_state;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a, r_b, r_res;
    logic             r_busy, r_done, r_cpc, r_ill;
    logic [WIDTH-1:0] w_res, w_diff;
    logic             w_cpc, w_ill;
    assign w_diff = r_a - r_b;
    always_comb begin
        w_res = '0;
        w_cpc = 1'b0;
        w_ill = 1'b0;
        case (r_op)
            OP_ADD:  w_res = r_a + r_b;
            OP_SUB:  w_res = w_diff;
            OP_AND:  w_res = r_a & r_b;
            OP_OR:   w_res = r_a | r_b;
            OP_XOR:  w_res = r_a ^ r_b;
            OP_BEQ:  begin w_res = w_diff; w_cpc = (r_a == r_b); end
            OP_BLT:  begin w_res = w_diff; w_cpc = ($signed(r_a) < $signed(r_b)); end
            default: w_ill = 1'b1;
        endcase
    end
`ifdef ALU_MUL_EN
    logic             w_mul_load, w_mul_done;
    logic [WIDTH-1:0] w_mul_res;
    // The engine captures the operands on the accepting edge, so it runs independently of r_a/r_b.
    assign w_mul_load = (r_state == ST_IDLE) && start && (opcode == OP_MUL);
    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_mul_load),
        .i_step (r_state == ST_MUL),
        .i_a    (ip_0),
        .i_b    (ip_1),
        .o_done (w_mul_done),
        .o_res  (w_mul_res)
    );
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cpc   <= 1'b0;
            r_ill   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (start) begin
                    r_op   <= opcode;
                    r_a    <= ip_0;
                    r_b    <= ip_1;
                    r_ill  <= 1'b0;
                    r_busy <= 1'b1;
`ifdef ALU_MUL_EN
                    r_state <= (opcode == OP_MUL) ? ST_MUL : ST_EXEC;
`else
                    r_state <= ST_EXEC;
`endif
                end
                ST_EXEC: begin
                    r_res   <= w_res;
                    r_cpc   <= w_cpc;
                    r_ill   <= w_ill;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_DONE;
                end
`ifdef ALU_MUL_EN
                ST_MUL: if (w_mul_done) begin
                    r_res   <= w_mul_res;
                    r_cpc   <= 1'b0;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_DONE;
                end
`endif
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
    assign busy      = r_busy;
    assign done      = r_done;
    assign op_0      = r_res;
    assign change_pc = r_cpc;
    assign illegal   = r_ill;
endmodule
